// File: rtl/div_pkg.sv
// Shared constants and state encoding for the iterative restoring divider.
package div_pkg;

  localparam int DIV_W = 32;
  localparam int CNT_W = $clog2(DIV_W);

  typedef logic [1:0] state_t;

  localparam state_t IDLE = 2'd0;
  localparam state_t CALC = 2'd1;
  localparam state_t FIX  = 2'd2;
  localparam state_t DONE = 2'd3;

endpackage

// File: rtl/div_if.sv
// Operand/result bus of the divider. div_by_zero exists only with DIV_BYZERO_FLAG_EN.
interface div_if #(parameter int W = div_pkg::DIV_W);

  // Handshake: a transfer happens on a rising edge where valid and ready are both 1.
  // in_ready is high only while the divider is idle; out_valid holds s/r stable
  // until out_ready is seen. Neither side waits on the other's valid to raise ready.
  logic         div_signed;
  logic [W-1:0] x;
  logic [W-1:0] y;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] s;
  logic [W-1:0] r;
  logic         out_valid;
  logic         out_ready;
  logic [1:0]   dbg_state;
`ifdef DIV_BYZERO_FLAG_EN
  logic         div_by_zero;
`endif

  modport master (
    output div_signed, x, y, in_valid, out_ready,
    input  in_ready, s, r, out_valid, dbg_state
`ifdef DIV_BYZERO_FLAG_EN
    , input div_by_zero
`endif
  );

  modport slave (
    input  div_signed, x, y, in_valid, out_ready,
    output in_ready, s, r, out_valid, dbg_state
`ifdef DIV_BYZERO_FLAG_EN
    , output div_by_zero
`endif
  );

endinterface

// File: rtl/div_step.sv
// One combinational restoring-division iteration on a {remainder, dividend/quotient} pair.
module div_step
  import div_pkg::*;
#(
  parameter int W = DIV_W
) (
  input  logic [2*W-1:0] pr,
  input  logic [W-1:0]   dvs,
  output logic [2*W-1:0] pr_next,
  output logic           q_bit
);

  // Shifted upper half needs W+1 bits: the remainder can approach 2^W-1 before the shift.
  logic [W:0]   top;
  logic [W-1:0] rem_next;

  assign top      = pr[2*W-1:W-1];
  assign q_bit    = (top >= {1'b0, dvs});
  // When the subtract succeeds the true difference is below 2^W, so modular W-bit math is exact.
  assign rem_next = q_bit ? (top[W-1:0] - dvs) : top[W-1:0];
  assign pr_next  = {rem_next, pr[W-2:0], q_bit};

endmodule

// File: rtl/div.sv
// Iterative radix-2 restoring divider, signed/unsigned, 33-cycle latency.
// Optional DIV_BYZERO_FLAG_EN: zero divisor finishes in one cycle and raises div_by_zero.
module div
  import div_pkg::*;
#(
  parameter int W = DIV_W
) (
  input logic div_clk,
  input logic reset,
  div_if.slave bus
);

  localparam int CW = $clog2(W);

  state_t         state;
  logic [CW-1:0]  counter;
  logic [2*W-1:0] pr;
  logic [W-1:0]   dvs;
  logic           sign_q;
  logic           sign_r;
  logic [W-1:0]   s_q;
  logic [W-1:0]   r_q;
  logic [2*W-1:0] pr_next;
  logic           q_bit;
  logic [W-1:0]   x_abs;
  logic [W-1:0]   y_abs;
`ifdef DIV_BYZERO_FLAG_EN
  logic           dbz_q;
`endif

  // Magnitudes stay W-bit unsigned, so |most-negative| is representable without overflow.
  assign x_abs = (bus.div_signed && bus.x[W-1]) ? -bus.x : bus.x;
  assign y_abs = (bus.div_signed && bus.y[W-1]) ? -bus.y : bus.y;

  div_step #(.W(W)) u_step (
    .pr      (pr),
    .dvs     (dvs),
    .pr_next (pr_next),
    .q_bit   (q_bit)
  );

  always_ff @(posedge div_clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      counter <= '0;
      pr      <= '0;
      dvs     <= '0;
      sign_q  <= 1'b0;
      sign_r  <= 1'b0;
      s_q     <= '0;
      r_q     <= '0;
`ifdef DIV_BYZERO_FLAG_EN
      dbz_q   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            counter <= '0;
            pr      <= {{W{1'b0}}, x_abs};
            dvs     <= y_abs;
            sign_q  <= (bus.x[W-1] ^ bus.y[W-1]) & bus.div_signed;
            sign_r  <= bus.x[W-1] & bus.div_signed;
            state   <= CALC;
`ifdef DIV_BYZERO_FLAG_EN
            if (bus.y == '0) begin
              s_q   <= '1;
              r_q   <= bus.x;
              dbz_q <= 1'b1;
              state <= DONE;
            end
`endif
          end
        end
        CALC: begin
          pr      <= pr_next;
          counter <= counter + 1'b1;
          if (counter == CW'(W - 1)) state <= FIX;
        end
        FIX: begin
          // Quotient sign follows the operand signs; remainder takes the dividend's sign.
          s_q   <= sign_q ? -pr[W-1:0] : pr[W-1:0];
          r_q   <= sign_r ? -pr[2*W-1:W] : pr[2*W-1:W];
          state <= DONE;
        end
        DONE: begin
          if (bus.out_ready) begin
            state <= IDLE;
`ifdef DIV_BYZERO_FLAG_EN
            dbz_q <= 1'b0;
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.s         = s_q;
  assign bus.r         = r_q;
  assign bus.dbg_state = state;
`ifdef DIV_BYZERO_FLAG_EN
  assign bus.div_by_zero = dbz_q;
`endif

endmodule

// File: tb/tb_div.sv
// Directed-vector bench for div: table of hand-computed results plus multi-cycle corner sequences.
module tb_div;
  import div_pkg::*;

  logic div_clk;
  logic reset;
  int   n_checks;
  int   n_fail;

  div_if #(.W(32)) bus ();

  div #(.W(32)) dut (
    .div_clk (div_clk),
    .reset   (reset),
    .bus     (bus.slave)
  );

  initial div_clk = 1'b0;
  always #5 div_clk = ~div_clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        sg;
    logic [31:0] x;
    logic [31:0] y;
    logic [31:0] s;
    logic [31:0] r;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input int id, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s id=%0d actual=%h required=%h", name, id, act, exp);
    end
  endtask

  function automatic int exp_latency(input logic [31:0] b);
`ifdef DIV_BYZERO_FLAG_EN
    return (b == 32'd0) ? 1 : 33;
`else
    return (b == 32'd0) ? 33 : 33;
`endif
  endfunction

  // Reference: magnitude divide, then apply quotient/remainder sign rules.
  task automatic ref_div(input logic sg, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] qs, output logic [31:0] rs);
    logic [31:0] ax, ay, q, rm;
    logic nq, nr;
    nr = sg & a[31];
    nq = sg & (a[31] ^ b[31]);
    ax = nr ? -a : a;
    ay = (sg & b[31]) ? -b : b;
    if (b == 32'd0) begin
      q  = 32'hFFFF_FFFF;
      rm = ax;
    end else begin
      q  = ax / ay;
      rm = ax % ay;
    end
    qs = nq ? -q : q;
    rs = nr ? -rm : rm;
`ifdef DIV_BYZERO_FLAG_EN
    if (b == 32'd0) begin
      qs = 32'hFFFF_FFFF;
      rs = a;
    end
`endif
  endtask

  task automatic wait_ready();
    int cyc;
    cyc = 0;
    while (!bus.in_ready && cyc < 100) begin
      @(negedge div_clk);
      cyc++;
    end
  endtask

  task automatic do_op(input int id, input logic sg, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] es, input logic [31:0] er);
    int cyc;
    @(negedge div_clk);
    wait_ready();
    bus.div_signed = sg;
    bus.x          = a;
    bus.y          = b;
    bus.in_valid   = 1'b1;
    @(posedge div_clk);
    #1;
    bus.in_valid   = 1'b0;
    bus.x          = $urandom;
    bus.y          = $urandom;
    bus.div_signed = ~sg;
    cyc = 0;
    do begin
      @(posedge div_clk);
      #1;
      cyc++;
    end while (!bus.out_valid && cyc < 200);
    check("latency", id, 32'(cyc), 32'(exp_latency(b)));
    check("quotient", id, bus.s, es);
    check("remainder", id, bus.r, er);
`ifdef DIV_BYZERO_FLAG_EN
    check("div_by_zero", id, 32'(bus.div_by_zero), 32'(b == 32'd0));
`endif
    @(negedge div_clk);
    bus.out_ready = 1'b1;
    @(posedge div_clk);
    #1;
    bus.out_ready = 1'b0;
    check("ready_after_take", id, 32'(bus.in_ready), 32'd1);
`ifdef DIV_BYZERO_FLAG_EN
    check("dbz_cleared", id, 32'(bus.div_by_zero), 32'd0);
`endif
  endtask

  task automatic hold_test();
    int cyc;
    @(negedge div_clk);
    wait_ready();
    bus.div_signed = 1'b0;
    bus.x          = 32'd1000;
    bus.y          = 32'd10;
    bus.in_valid   = 1'b1;
    @(posedge div_clk);
    #1;
    bus.in_valid = 1'b0;
    cyc = 0;
    do begin
      @(posedge div_clk);
      #1;
      cyc++;
    end while (!bus.out_valid && cyc < 200);
    check("hold_latency", 0, 32'(cyc), 32'd33);
    @(negedge div_clk);
    bus.in_valid = 1'b1;
    bus.x        = 32'd7;
    bus.y        = 32'd1;
    for (int i = 0; i < 10; i++) begin
      @(posedge div_clk);
      #1;
      check("hold_valid", i, 32'(bus.out_valid), 32'd1);
      check("hold_s", i, bus.s, 32'd100);
      check("hold_r", i, bus.r, 32'd0);
      check("hold_in_ready", i, 32'(bus.in_ready), 32'd0);
    end
    @(negedge div_clk);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge div_clk);
    #1;
    bus.out_ready = 1'b0;
    check("hold_release_ready", 0, 32'(bus.in_ready), 32'd1);
    check("hold_release_valid", 0, 32'(bus.out_valid), 32'd0);
  endtask

  task automatic reset_test();
    @(negedge div_clk);
    wait_ready();
    bus.div_signed = 1'b0;
    bus.x          = 32'd1000;
    bus.y          = 32'd7;
    bus.in_valid   = 1'b1;
    @(posedge div_clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (10) @(posedge div_clk);
    #3;
    check("mid_calc_state", 0, 32'(bus.dbg_state), 32'(CALC));
    reset = 1'b1;
    #1;
    check("rst_out_valid", 0, 32'(bus.out_valid), 32'd0);
    check("rst_in_ready", 0, 32'(bus.in_ready), 32'd1);
    check("rst_s", 0, bus.s, 32'd0);
    check("rst_r", 0, bus.r, 32'd0);
    @(negedge div_clk);
    reset = 1'b0;
    do_op(100, 1'b0, 32'd9, 32'd3, 32'd3, 32'd0);
  endtask

  initial begin
    logic [31:0] a, b, es, er;
    logic        sg;
    logic [31:0] edges[5];
    n_checks = 0;
    n_fail   = 0;
    edges[0] = 32'd0;
    edges[1] = 32'd1;
    edges[2] = 32'hFFFF_FFFF;
    edges[3] = 32'h8000_0000;
    edges[4] = 32'h7FFF_FFFF;

    vecs[0]  = '{1'b0, 32'd100,         32'd7,           32'd14,          32'd2};
    vecs[1]  = '{1'b1, 32'hFFFF_FFF9,   32'd2,           32'hFFFF_FFFD,   32'hFFFF_FFFF};
    vecs[2]  = '{1'b1, 32'd7,           32'hFFFF_FFFE,   32'hFFFF_FFFD,   32'd1};
    vecs[3]  = '{1'b1, 32'h8000_0000,   32'hFFFF_FFFF,   32'h8000_0000,   32'd0};
    vecs[4]  = '{1'b0, 32'h8000_0000,   32'hFFFF_FFFF,   32'd0,           32'h8000_0000};
    vecs[5]  = '{1'b0, 32'd5,           32'd0,           32'hFFFF_FFFF,   32'd5};
    vecs[6]  = '{1'b1, 32'hFFFF_FFF9,   32'hFFFF_FFFE,   32'd3,           32'hFFFF_FFFF};
    vecs[7]  = '{1'b0, 32'hFFFF_FFFF,   32'd1,           32'hFFFF_FFFF,   32'd0};
    vecs[8]  = '{1'b0, 32'd0,           32'd5,           32'd0,           32'd0};
`ifdef DIV_BYZERO_FLAG_EN
    vecs[9]  = '{1'b1, 32'hFFFF_FFFB,   32'd0,           32'hFFFF_FFFF,   32'hFFFF_FFFB};
`else
    vecs[9]  = '{1'b1, 32'hFFFF_FFFB,   32'd0,           32'd1,           32'hFFFF_FFFB};
`endif
    vecs[10] = '{1'b0, 32'd7,           32'd9,           32'd0,           32'd7};
    vecs[11] = '{1'b1, 32'h8000_0000,   32'd2,           32'hC000_0000,   32'd0};

    reset          = 1'b1;
    bus.div_signed = 1'b0;
    bus.x          = '0;
    bus.y          = '0;
    bus.in_valid   = 1'b0;
    bus.out_ready  = 1'b0;
    #23;
    check("reset_in_ready", 0, 32'(bus.in_ready), 32'd1);
    check("reset_out_valid", 0, 32'(bus.out_valid), 32'd0);
    check("reset_s", 0, bus.s, 32'd0);
    check("reset_r", 0, bus.r, 32'd0);
    check("reset_state", 0, 32'(bus.dbg_state), 32'(IDLE));
`ifdef DIV_BYZERO_FLAG_EN
    check("reset_dbz", 0, 32'(bus.div_by_zero), 32'd0);
`endif
    @(negedge div_clk);
    reset = 1'b0;

    for (int i = 0; i < 12; i++)
      do_op(i, vecs[i].sg, vecs[i].x, vecs[i].y, vecs[i].s, vecs[i].r);

    hold_test();
    reset_test();

    for (int i = 0; i < 300; i++) begin
      sg = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 3))
        0: begin a = $urandom; b = $urandom; end
        1: begin
          a = $urandom_range(0, 200) - 32'd100;
          b = $urandom_range(0, 20) - 32'd10;
        end
        2: begin a = $urandom; b = 32'd0; end
        default: begin
          a = edges[$urandom_range(0, 4)];
          b = edges[$urandom_range(0, 4)];
        end
      endcase
      ref_div(sg, a, b, es, er);
      do_op(1000 + i, sg, a, b, es, er);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
